// File: rtl/exu_pkg.sv
// Shared encodings for the EXU sequencer: ex_op codes, RV32M funct3 codes,
// sequencer states and small decode helpers.
package exu_pkg;

    localparam int XLEN_W = 32;

    typedef enum logic [3:0] {
        EX_NONE   = 4'd0,
        EX_AUIPC  = 4'd1,
        EX_LUI    = 4'd2,
        EX_JAL    = 4'd3,
        EX_JALR   = 4'd4,
        EX_LOAD   = 4'd5,
        EX_STORE  = 4'd6,
        EX_BRANCH = 4'd7,
        EX_OPIMM  = 4'd8,
        EX_OP     = 4'd9
    } ex_op_e;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MUL is treated as unsigned: its low product word does not depend on sign.
    function automatic logic mdu_a_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic mdu_b_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign fixup and zero-cycle special divides.
module mdu_iter
    import exu_pkg::*;
#(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int CW = 6;

    logic [CW-1:0] count_reg;
    logic          busy_reg;
    logic [2:0]    op_reg;
    logic [31:0]   hi_reg;
    logic [31:0]   lo_reg;
    logic [31:0]   den_reg;
    logic          neg_q_reg;
    logic          neg_r_reg;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        special;
    logic [31:0] special_result;

    always_comb begin
        a_neg = mdu_a_signed(op) & a[31];
        b_neg = mdu_b_signed(op) & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        special        = 1'b0;
        special_result = 32'd0;
        if (op[2]) begin
            if (b == 32'd0) begin
                special        = 1'b1;
                special_result = op[1] ? a : 32'hFFFF_FFFF;
            end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                special        = 1'b1;
                special_result = op[1] ? 32'd0 : 32'h8000_0000;
            end
        end
    end

    // One iteration step computed from the registered state.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] hi_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, den_reg} : 33'd0);
        div_shift = {hi_reg, lo_reg[31]};
        div_diff  = div_shift - {1'b0, den_reg};
        div_ge    = ~div_diff[32];
        if (op_reg[2]) begin
            hi_step = div_ge ? div_diff[31:0] : div_shift[31:0];
            lo_step = {lo_reg[30:0], div_ge};
        end else begin
            hi_step = mul_sum[32:1];
            lo_step = {mul_sum[0], lo_reg[31:1]};
        end
    end

    logic        last;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix, final_result;

    always_comb begin
        last     = busy_reg && (count_reg == CW'(CYCLES - 1));
        prod_fix = neg_q_reg ? (64'd0 - {hi_step, lo_step}) : {hi_step, lo_step};
        quot_fix = neg_q_reg ? (32'd0 - lo_step) : lo_step;
        rem_fix  = neg_r_reg ? (32'd0 - hi_step) : hi_step;
        if (op_reg[2])
            final_result = op_reg[1] ? rem_fix : quot_fix;
        else
            final_result = (op_reg == MDU_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    end

    assign busy   = busy_reg;
    assign done   = (start & special) | last;
    assign result = (start & special) ? special_result : final_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
            op_reg    <= 3'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            den_reg   <= 32'd0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (start && !special) begin
            count_reg <= '0;
            busy_reg  <= 1'b1;
            op_reg    <= op;
            hi_reg    <= 32'd0;
            lo_reg    <= op[2] ? a_mag : b_mag;
            den_reg   <= op[2] ? b_mag : a_mag;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
        end else if (busy_reg) begin
            hi_reg    <= hi_step;
            lo_reg    <= lo_step;
            count_reg <= count_reg + 1'b1;
            if (last)
                busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/exu_ctrl.sv
// Decode-to-writeback sequencer around the combinational EXU with an output
// result register. EXU_MDU_EN enables the iterative RV32M path.
module exu_ctrl
    import exu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MDU_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_alu_op,
    input  logic [3:0]      in_ex_op,
    input  logic            in_is_mdu,
    input  logic [2:0]      in_mdu_op,
    output logic [XLEN-1:0] exu_pc,
    output logic [XLEN-1:0] exu_rs1_data,
    output logic [XLEN-1:0] exu_rs2_data,
    output logic [XLEN-1:0] exu_imm,
    output logic [4:0]      exu_rd,
    output logic [4:0]      exu_alu_op,
    output logic [3:0]      exu_ex_op,
    input  logic [XLEN-1:0] exu_alu_data,
    input  logic            exu_compare_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            out_taken
);

    assign exu_pc       = in_pc;
    assign exu_rs1_data = in_rs1_data;
    assign exu_rs2_data = in_rs2_data;
    assign exu_imm      = in_imm;
    assign exu_rd       = in_rd;
    assign exu_alu_op   = in_alu_op;
    assign exu_ex_op    = in_ex_op;

    state_e          state_reg, state_next;
    logic [XLEN-1:0] out_data_reg, out_data_next;
    logic [4:0]      out_rd_reg, out_rd_next;
    logic            out_taken_reg, out_taken_next;
    logic            accept;

    assign in_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg == ST_DONE);
    assign out_data  = out_data_reg;
    assign out_rd    = out_rd_reg;
    assign out_taken = out_taken_reg;

`ifdef EXU_MDU_EN
    logic            mdu_start;
    logic            mdu_done;
    logic            unused_mdu_busy;
    logic [XLEN-1:0] mdu_result;

    assign mdu_start = accept & in_is_mdu;

    mdu_iter #(
        .CYCLES (MDU_CYCLES)
    ) u_mdu_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_start),
        .op     (in_mdu_op),
        .a      (in_rs1_data),
        .b      (in_rs2_data),
        .busy   (unused_mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );
`else
    logic unused_mdu;
    assign unused_mdu = ^{in_mdu_op, MDU_CYCLES[0]};
`endif

    always_comb begin
        state_next     = state_reg;
        out_data_next  = out_data_reg;
        out_rd_next    = out_rd_reg;
        out_taken_next = out_taken_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (state_reg == ST_DONE && out_ready)
                    state_next = ST_IDLE;
                // A DONE slot being drained can take the next instruction directly.
                if (accept) begin
                    out_rd_next = in_rd;
                    state_next  = ST_DONE;
                    if (in_is_mdu) begin
                        out_taken_next = 1'b0;
`ifdef EXU_MDU_EN
                        if (mdu_done)
                            out_data_next = mdu_result;
                        else
                            state_next = ST_BUSY;
`else
                        out_data_next = '0;
`endif
                    end else begin
                        out_data_next  = exu_alu_data;
                        out_taken_next = exu_compare_result;
                    end
                end
            end
`ifdef EXU_MDU_EN
            ST_BUSY: begin
                if (mdu_done) begin
                    out_data_next = mdu_result;
                    state_next    = ST_DONE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_data_reg  <= '0;
            out_rd_reg    <= 5'd0;
            out_taken_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_data_reg  <= out_data_next;
            out_rd_reg    <= out_rd_next;
            out_taken_reg <= out_taken_next;
        end
    end

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed bench for exu_ctrl with a behavioural EXU (add / equality compare).
module tb_exu_ctrl;
    import exu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [4:0]  in_alu_op;
    logic [3:0]  in_ex_op;
    logic        in_is_mdu;
    logic [2:0]  in_mdu_op;
    logic [31:0] exu_pc, exu_rs1_data, exu_rs2_data, exu_imm;
    logic [4:0]  exu_rd, exu_alu_op;
    logic [3:0]  exu_ex_op;
    logic [31:0] exu_alu_data;
    logic        exu_compare_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_taken;

    int n_cmp = 0;
    int n_err = 0;

    exu_ctrl #(.XLEN(32), .MDU_CYCLES(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_pc              (in_pc),
        .in_rd              (in_rd),
        .in_rs1_data        (in_rs1_data),
        .in_rs2_data        (in_rs2_data),
        .in_imm             (in_imm),
        .in_alu_op          (in_alu_op),
        .in_ex_op           (in_ex_op),
        .in_is_mdu          (in_is_mdu),
        .in_mdu_op          (in_mdu_op),
        .exu_pc             (exu_pc),
        .exu_rs1_data       (exu_rs1_data),
        .exu_rs2_data       (exu_rs2_data),
        .exu_imm            (exu_imm),
        .exu_rd             (exu_rd),
        .exu_alu_op         (exu_alu_op),
        .exu_ex_op          (exu_ex_op),
        .exu_alu_data       (exu_alu_data),
        .exu_compare_result (exu_compare_result),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_rd             (out_rd),
        .out_taken          (out_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in EXU: immediate add for OP-IMM, register add otherwise.
    always_comb begin
        exu_alu_data       = exu_rs1_data + ((exu_ex_op == 4'd8) ? exu_imm : exu_rs2_data);
        exu_compare_result = (exu_rs1_data == exu_rs2_data);
    end

    always @(negedge clk)
        if (!rst && out_valid && out_ready)
            $display("txn rd=%0d data=%08h taken=%0b", out_rd, out_data, out_taken);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ex, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                         input logic mdu, input logic [2:0] mop);
        in_valid    = v;
        in_ex_op    = ex;
        in_rs1_data = a;
        in_rs2_data = b;
        in_imm      = imm;
        in_rd       = rd;
        in_is_mdu   = mdu;
        in_mdu_op   = mop;
        in_pc       = 32'h0000_1000;
        in_alu_op   = 5'd0;
    endtask

    task automatic run_mdu(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input int lat);
        int waited;
        int ready_seen;
        logic [31:0] exp_res;
        int exp_lat;
`ifdef EXU_MDU_EN
        exp_res = res;
        exp_lat = lat;
`else
        exp_res = 32'd0;
        exp_lat = 1;
`endif
        drive(1'b1, 4'd9, a, b, 32'd0, 5'd5, 1'b1, op);
        tick();
        in_valid   = 1'b0;
        waited     = 1;
        ready_seen = 0;
        while (!out_valid && waited < 40) begin
            if (in_ready) ready_seen++;
            tick();
            waited++;
        end
        check({tag, "_lat"}, waited, exp_lat);
        check({tag, "_busy_ready"}, ready_seen, 0);
        check({tag, "_data"}, out_data, exp_res);
        check({tag, "_rd"}, {27'd0, out_rd}, 32'd5);
        check({tag, "_taken"}, {31'd0, out_taken}, 32'd0);
        tick();
    endtask

    logic [31:0] b2b_a [3] = '{32'd1, 32'd10, 32'd100};
    logic [31:0] b2b_b [3] = '{32'd2, 32'd20, 32'd200};
    logic [31:0] b2b_r [3] = '{32'd3, 32'd30, 32'd300};

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int seen;
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 3'd0);
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_taken", {31'd0, out_taken}, 32'd0);
        rst = 1'b0;

        // ADDI x3 = 5 + 7
        out_ready = 1'b1;
        drive(1'b1, 4'd8, 32'd5, 32'd0, 32'd7, 5'd3, 1'b0, 3'd0);
        #1;
        check("addi_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_data", out_data, 32'd12);
        check("addi_rd", {27'd0, out_rd}, 32'd3);
        tick();
        check("addi_drained", {31'd0, out_valid}, 32'd0);

        // Three back-to-back ADDs, no bubbles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd9, b2b_a[i], b2b_b[i], 32'd0, 5'(i + 1), 1'b0, 3'd0);
            tick();
            check($sformatf("b2b%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("b2b%0d_data", i), out_data, b2b_r[i]);
            check($sformatf("b2b%0d_rd", i), {27'd0, out_rd}, 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        check("b2b_drained", {31'd0, out_valid}, 32'd0);

        // RV32M vectors; specials complete in one cycle
        run_mdu("mulh_m1x2", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_mdu("mulh_big", 3'd1, 32'h4000_0000, 32'h0000_0004, 32'h0000_0001, 33);
        run_mdu("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 33);
        run_mdu("mul_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33);
        run_mdu("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_mdu("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_mdu("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_mdu("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_mdu("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_mdu("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_mdu("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_mdu("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_mdu("remu_by0", 3'd7, 32'd9, 32'd0, 32'd9, 1);
        run_mdu("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

        // Taken branch held under back-pressure, next op waits at the input
        out_ready = 1'b0;
        drive(1'b1, 4'd7, 32'd4, 32'd4, 32'd0, 5'd9, 1'b0, 3'd0);
        tick();
        check("br_valid", {31'd0, out_valid}, 32'd1);
        check("br_taken", {31'd0, out_taken}, 32'd1);
        check("br_data", out_data, 32'd8);
        check("br_rd", {27'd0, out_rd}, 32'd9);
        drive(1'b1, 4'd9, 32'd1, 32'd1, 32'd0, 5'd4, 1'b0, 3'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready || !out_valid || out_data != 32'd8 || out_rd != 5'd9 || !out_taken)
                bad++;
            tick();
        end
        check("br_stall_stable", bad, 0);
        out_ready = 1'b1;
        #1;
        check("br_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("after_br_data", out_data, 32'd2);
        check("after_br_rd", {27'd0, out_rd}, 32'd4);
        tick();
        check("after_br_drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a DIVU
        out_ready = 1'b0;
        drive(1'b1, 4'd9, 32'd100, 32'd7, 32'd0, 5'd6, 1'b1, 3'd5);
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data", out_data, 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst_no_result", seen, 0);

        drive(1'b1, 4'd8, 32'd20, 32'd0, 32'd22, 5'd7, 1'b0, 3'd0);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_data", out_data, 32'd42);
        check("post_rst_rd", {27'd0, out_rd}, 32'd7);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
